ecc_apb_job_driver: RTL and testbench

Upstream job sequencer for the ECC encoder/decoder top. Accepts one job per valid/ready handshake (mode, codeword width, data, noise) and issues APB write transfers into the ECC register bank, writing CTRL last, since the CTRL write raises start. It then waits for operation_done, captures data_out and num_of_errors, and returns them on a valid/ready result port. A watchdog bounds the wait, and shadow registers suppress redundant width and noise writes.

---
 rtl/ecc_apb_job_driver_pkg.sv | 53 +++++
 rtl/ecc_drv_watchdog.sv | 37 +++
 rtl/ecc_apb_job_driver.sv | 246 ++++++++++++++++++++++++
 tb/tb_ecc_apb_job_driver.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_apb_job_driver_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : ecc_drv_pkg
//  Description: Shared types and constants for the ECC APB job driver:
//               sequencer states, ECC register map, ctrl encodings and the
//               APB write-list entry type.
//  Revision   : 1.0 - initial release
// ============================================================================
package ecc_drv_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SETUP     = 3'd1,
        S_ACCESS    = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RESULT    = 3'd4
    } drv_state_t;

    // Width of a register offset and of the payload carried by a list entry
    localparam int ENTRY_ADDR_W = 8;
    localparam int ENTRY_DATA_W = 32;

    // ECC register bank offsets
    localparam logic [ENTRY_ADDR_W-1:0] ADDR_CTRL           = 8'h00;
    localparam logic [ENTRY_ADDR_W-1:0] ADDR_DATA_IN        = 8'h04;
    localparam logic [ENTRY_ADDR_W-1:0] ADDR_CODEWORD_WIDTH = 8'h08;
    localparam logic [ENTRY_ADDR_W-1:0] ADDR_NOISE          = 8'h0C;

    // CTRL register encodings
    localparam logic [1:0] ENCODER_ONLY = 2'd0;
    localparam logic [1:0] DECODER_ONLY = 2'd1;
    localparam logic [1:0] FULL_CHANNEL = 2'd2;

    // One pending APB write: register offset plus zero-extended payload
    typedef struct packed {
        logic [ENTRY_ADDR_W-1:0] addr;
        logic [ENTRY_DATA_W-1:0] data;
    } wr_entry_t;

    // Pack an offset and payload into a write-list entry
    function automatic wr_entry_t make_entry(
        input logic [ENTRY_ADDR_W-1:0] addr,
        input logic [ENTRY_DATA_W-1:0] data
    );
        wr_entry_t e;
        e.addr = addr;
        e.data = data;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ecc_drv_watchdog.sv
`default_nettype none
// ============================================================================
//  Module     : ecc_drv_watchdog
//  Description: Bounded wait counter. Counts enabled cycles from zero and
//               flags expiry on the TIMEOUT_CYCLES-th enabled cycle.
//  Revision   : 1.0 - initial release
// ============================================================================
module ecc_drv_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int              CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Count enabled cycles; saturate on the last value so it never wraps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != C_LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = i_enable && (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/ecc_apb_job_driver.sv
`default_nettype none
// ============================================================================
//  Module     : ecc_apb_job_driver
//  Description: Takes one ECC job per handshake, writes the ECC register bank
//               over APB (CTRL last, since it starts the operation), waits for
//               operation_done under a watchdog and returns the result.
//               Shadow copies of WIDTH and NOISE skip redundant writes.
//  Revision   : 1.0 - initial release
// ============================================================================
module ecc_apb_job_driver
    import ecc_drv_pkg::*;
#(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int DATA_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [1:0]                 job_ctrl,
    input  logic [1:0]                 job_width,
    input  logic [DATA_WIDTH-1:0]      job_data,
    input  logic [DATA_WIDTH-1:0]      job_noise,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic [AMBA_WORD-1:0]       PWDATA,
    input  logic                       operation_done,
    input  logic [DATA_WIDTH-1:0]      data_out,
    input  logic [1:0]                 num_of_errors,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [DATA_WIDTH-1:0]      res_data,
    output logic [1:0]                 res_errors,
    output logic                       res_timeout
);

    drv_state_t r_state;
    drv_state_t w_state_nxt;

    // Write list captured at accept time, its length and the current entry
    wr_entry_t  r_list [4];
    wr_entry_t  w_list [4];
    logic [2:0] r_num;
    logic [2:0] w_num;
    logic [1:0] r_idx;
    logic       w_last;
    logic       w_accept;
    wr_entry_t  w_next_entry;

    logic       w_need_width;
    logic       w_need_noise;
    logic [1:0] w_pos_data;

    // Job fields needed later to refresh the shadows
    logic [1:0]            r_job_width;
    logic [DATA_WIDTH-1:0] r_job_noise;

    // Shadows of what the ECC bank currently holds
    logic [1:0]            r_width_shadow;
    logic                  r_width_valid;
    logic [DATA_WIDTH-1:0] r_noise_shadow;
    logic                  r_noise_valid;

    // Registered outputs
    logic                       r_psel;
    logic                       r_penable;
    logic [AMBA_ADDR_WIDTH-1:0] r_paddr;
    logic [AMBA_WORD-1:0]       r_pwdata;
    logic                       r_job_ready;
    logic                       r_res_valid;
    logic [DATA_WIDTH-1:0]      r_res_data;
    logic [1:0]                 r_res_errors;
    logic                       r_res_timeout;

    logic w_wd_expire;

    ecc_drv_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (r_state != S_WAIT_DONE),
        .i_enable (r_state == S_WAIT_DONE),
        .o_expire (w_wd_expire)
    );

    // Build the ordered write list for the offered job: WIDTH?, NOISE?, DATA, CTRL
    always_comb begin
        w_need_width = !r_width_valid || (r_width_shadow != job_width);
        w_need_noise = (job_ctrl == FULL_CHANNEL) &&
                       (!r_noise_valid || (r_noise_shadow != job_noise));
        w_pos_data   = {1'b0, w_need_width} + {1'b0, w_need_noise};
        for (int i = 0; i < 4; i++) begin
            w_list[i] = '0;
        end
        if (w_need_width) begin
            w_list[0] = make_entry(ADDR_CODEWORD_WIDTH, ENTRY_DATA_W'(job_width));
        end
        if (w_need_noise) begin
            w_list[{1'b0, w_need_width}] = make_entry(ADDR_NOISE, ENTRY_DATA_W'(job_noise));
        end
        w_list[w_pos_data]        = make_entry(ADDR_DATA_IN, ENTRY_DATA_W'(job_data));
        w_list[w_pos_data + 2'd1] = make_entry(ADDR_CTRL, ENTRY_DATA_W'(job_ctrl));
        w_num = {1'b0, w_pos_data} + 3'd2;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and selection of the entry to present next
    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_last       = ({1'b0, r_idx} == (r_num - 3'd1));
        w_next_entry = (r_state == S_IDLE) ? w_list[0] : r_list[r_idx + 2'd1];
        case (r_state)
            S_IDLE: begin
                if (job_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                w_state_nxt = w_last ? S_WAIT_DONE : S_SETUP;
            end
            S_WAIT_DONE: begin
                // Done on the final count cycle still counts as success
                if (operation_done || w_wd_expire) begin
                    w_state_nxt = S_RESULT;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Job latch, list walk, shadow tracking and result capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                r_list[i] <= '0;
            end
            r_num          <= '0;
            r_idx          <= '0;
            r_job_width    <= '0;
            r_job_noise    <= '0;
            r_width_shadow <= '0;
            r_width_valid  <= 1'b0;
            r_noise_shadow <= '0;
            r_noise_valid  <= 1'b0;
            r_res_data     <= '0;
            r_res_errors   <= '0;
            r_res_timeout  <= 1'b0;
        end else begin
            if (w_accept) begin
                for (int i = 0; i < 4; i++) begin
                    r_list[i] <= w_list[i];
                end
                r_num       <= w_num;
                r_idx       <= '0;
                r_job_width <= job_width;
                r_job_noise <= job_noise;
            end
            if (r_state == S_ACCESS) begin
                if (!w_last) begin
                    r_idx <= r_idx + 2'd1;
                end
                if (r_list[r_idx].addr == ADDR_CODEWORD_WIDTH) begin
                    r_width_shadow <= r_job_width;
                    r_width_valid  <= 1'b1;
                end
                if (r_list[r_idx].addr == ADDR_NOISE) begin
                    r_noise_shadow <= r_job_noise;
                    r_noise_valid  <= 1'b1;
                end
            end
            if (r_state == S_WAIT_DONE) begin
                if (operation_done) begin
                    r_res_data    <= data_out;
                    r_res_errors  <= num_of_errors;
                    r_res_timeout <= 1'b0;
                end else if (w_wd_expire) begin
                    // The ECC bank state is unknown after a timeout
                    r_res_data     <= '0;
                    r_res_errors   <= '0;
                    r_res_timeout  <= 1'b1;
                    r_width_valid  <= 1'b0;
                    r_noise_valid  <= 1'b0;
                end
            end
        end
    end

    // Output registers driven from the upcoming state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_job_ready <= 1'b1;
            r_res_valid <= 1'b0;
        end else begin
            r_psel      <= (w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS);
            r_penable   <= (w_state_nxt == S_ACCESS);
            r_job_ready <= (w_state_nxt == S_IDLE);
            r_res_valid <= (w_state_nxt == S_RESULT);
            if (w_state_nxt == S_SETUP) begin
                r_paddr  <= AMBA_ADDR_WIDTH'(w_next_entry.addr);
                r_pwdata <= AMBA_WORD'(w_next_entry.data);
            end
        end
    end

    assign PSEL        = r_psel;
    assign PENABLE     = r_penable;
    assign PWRITE      = r_psel;
    assign PADDR       = r_paddr;
    assign PWDATA      = r_pwdata;
    assign job_ready   = r_job_ready;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign res_errors  = r_res_errors;
    assign res_timeout = r_res_timeout;

endmodule
`default_nettype wire

// File: tb/tb_ecc_apb_job_driver.sv
`default_nettype none
// ============================================================================
//  Module     : tb_ecc_apb_job_driver
//  Description: Directed self-checking bench for ecc_apb_job_driver; the
//               bench plays the role of the ECC top (operation_done/data_out).
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_ecc_apb_job_driver;

    localparam int AW  = 32;
    localparam int ADW = 20;
    localparam int DW  = 32;
    localparam int TO  = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           job_valid = 1'b0;
    logic           job_ready;
    logic [1:0]     job_ctrl = '0;
    logic [1:0]     job_width = '0;
    logic [DW-1:0]  job_data = '0;
    logic [DW-1:0]  job_noise = '0;
    logic           PSEL, PENABLE, PWRITE;
    logic [ADW-1:0] PADDR;
    logic [AW-1:0]  PWDATA;
    logic           operation_done = 1'b0;
    logic [DW-1:0]  data_out = '0;
    logic [1:0]     num_of_errors = '0;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic [DW-1:0]  res_data;
    logic [1:0]     res_errors;
    logic           res_timeout;

    int checks = 0;
    int errors = 0;

    ecc_apb_job_driver #(
        .AMBA_WORD       (AW),
        .AMBA_ADDR_WIDTH (ADW),
        .DATA_WIDTH      (DW),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .job_valid      (job_valid),
        .job_ready      (job_ready),
        .job_ctrl       (job_ctrl),
        .job_width      (job_width),
        .job_data       (job_data),
        .job_noise      (job_noise),
        .PSEL           (PSEL),
        .PENABLE        (PENABLE),
        .PWRITE         (PWRITE),
        .PADDR          (PADDR),
        .PWDATA         (PWDATA),
        .operation_done (operation_done),
        .data_out       (data_out),
        .num_of_errors  (num_of_errors),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data),
        .res_errors     (res_errors),
        .res_timeout    (res_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offer a job and follow its APB writes cycle by cycle against the expected list
    task automatic drive_job(input logic [1:0] ctrl, input logic [1:0] width,
                             input logic [31:0] data, input logic [31:0] noise,
                             input logic [3:0][7:0] eaddr, input logic [3:0][31:0] edata,
                             input int n);
        checks++;
        if (job_ready !== 1'b1) begin
            errors++;
            $display("FAIL job_ready_idle: got %b want 1", job_ready);
        end
        job_valid = 1'b1; job_ctrl = ctrl; job_width = width; job_data = data; job_noise = noise;
        tick;
        job_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            checks++;
            if ({PSEL, PENABLE, PWRITE} !== 3'b101 || PADDR !== {12'h0, eaddr[k]} || PWDATA !== edata[k]) begin
                errors++;
                $display("FAIL apb_setup[%0d]: got sel/en/wr=%b%b%b addr=%h data=%h want 101 addr=%h data=%h",
                         k, PSEL, PENABLE, PWRITE, PADDR, PWDATA, eaddr[k], edata[k]);
            end
            tick;
            checks++;
            if ({PSEL, PENABLE, PWRITE} !== 3'b111 || PADDR !== {12'h0, eaddr[k]} || PWDATA !== edata[k]) begin
                errors++;
                $display("FAIL apb_access[%0d]: got sel/en/wr=%b%b%b addr=%h data=%h want 111 addr=%h data=%h",
                         k, PSEL, PENABLE, PWRITE, PADDR, PWDATA, eaddr[k], edata[k]);
            end
            tick;
        end
        checks++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || job_ready !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_done_entry: got sel=%b en=%b job_ready=%b res_valid=%b want 0 0 0 0",
                     PSEL, PENABLE, job_ready, res_valid);
        end
    endtask

    // After `delay` WAIT_DONE cycles pulse done, check the result, then accept it
    task automatic complete_done(input int delay, input logic [31:0] dout, input logic [1:0] nerr);
        repeat (delay) tick;
        operation_done = 1'b1; data_out = dout; num_of_errors = nerr;
        tick;
        operation_done = 1'b0; data_out = 32'hDEAD_BEEF; num_of_errors = 2'd3;
        checks++;
        if (res_valid !== 1'b1 || res_data !== dout || res_errors !== nerr || res_timeout !== 1'b0 || job_ready !== 1'b0) begin
            errors++;
            $display("FAIL result: got valid=%b data=%h err=%0d to=%b job_ready=%b want 1 %h %0d 0 0",
                     res_valid, res_data, res_errors, res_timeout, job_ready, dout, nerr);
        end
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || job_ready !== 1'b1) begin
            errors++;
            $display("FAIL result_accept: got valid=%b job_ready=%b want 0 1", res_valid, job_ready);
        end
    endtask

    // Expect the watchdog result exactly TO cycles after entering WAIT_DONE, then accept it
    task automatic expect_timeout;
        data_out = 32'h1357_2468; num_of_errors = 2'd2;
        repeat (TO - 1) tick;
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: got res_valid=%b want 0", res_valid);
        end
        tick;
        checks++;
        if (res_valid !== 1'b1 || res_timeout !== 1'b1 || res_data !== 32'h0 || res_errors !== 2'd0) begin
            errors++;
            $display("FAIL timeout_result: got valid=%b to=%b data=%h err=%0d want 1 1 0 0",
                     res_valid, res_timeout, res_data, res_errors);
        end
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || job_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_accept: got valid=%b job_ready=%b want 0 1", res_valid, job_ready);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({PSEL, PENABLE, PWRITE} !== 3'b000 || PADDR !== '0 || PWDATA !== '0) begin
            errors++;
            $display("FAIL reset_apb: got sel/en/wr=%b%b%b addr=%h data=%h want 000 0 0",
                     PSEL, PENABLE, PWRITE, PADDR, PWDATA);
        end
        checks++;
        if (res_valid !== 1'b0 || res_timeout !== 1'b0 || res_data !== '0 || res_errors !== '0 || job_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_result: got valid=%b to=%b data=%h err=%0d job_ready=%b want 0 0 0 0 1",
                     res_valid, res_timeout, res_data, res_errors, job_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        tick;
    endtask

    task automatic test_first_job;
        drive_job(2'd0, 2'd2, 32'h0000_1234, 32'h0,
                  {8'h00, 8'h00, 8'h04, 8'h08}, {32'h0, 32'h0, 32'h1234, 32'h2}, 3);
        complete_done(2, 32'h0000_1234, 2'd0);
    endtask

    task automatic test_repeat_job;
        drive_job(2'd0, 2'd2, 32'h0000_1234, 32'h0,
                  {8'h00, 8'h00, 8'h00, 8'h04}, {32'h0, 32'h0, 32'h0, 32'h1234}, 2);
        complete_done(0, 32'h0000_1234, 2'd0);
    endtask

    task automatic test_full_channel;
        drive_job(2'd2, 2'd1, 32'h0000_0055, 32'h0000_0001,
                  {8'h00, 8'h04, 8'h0C, 8'h08}, {32'h2, 32'h55, 32'h1, 32'h1}, 4);
        complete_done(3, 32'h0000_0054, 2'd1);
        drive_job(2'd2, 2'd1, 32'h0000_0055, 32'h0000_0001,
                  {8'h00, 8'h00, 8'h00, 8'h04}, {32'h0, 32'h0, 32'h2, 32'h55}, 2);
        complete_done(1, 32'h0000_0055, 2'd1);
    endtask

    task automatic test_timeout;
        drive_job(2'd0, 2'd1, 32'h0000_0099, 32'h0,
                  {8'h00, 8'h00, 8'h00, 8'h04}, {32'h0, 32'h0, 32'h0, 32'h99}, 2);
        expect_timeout();
        // Shadows were dropped, so width comes back; done on the last count cycle wins
        drive_job(2'd0, 2'd1, 32'h0000_0099, 32'h0,
                  {8'h00, 8'h00, 8'h04, 8'h08}, {32'h0, 32'h0, 32'h99, 32'h1}, 3);
        complete_done(TO - 1, 32'h0000_0098, 2'd0);
    endtask

    task automatic test_backpressure;
        drive_job(2'd0, 2'd1, 32'h0000_4321, 32'h0,
                  {8'h00, 8'h00, 8'h00, 8'h04}, {32'h0, 32'h0, 32'h0, 32'h4321}, 2);
        operation_done = 1'b1; data_out = 32'h0000_ABCD; num_of_errors = 2'd2;
        tick;
        operation_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (res_valid !== 1'b1 || res_data !== 32'h0000_ABCD || res_errors !== 2'd2 || job_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure[%0d]: got valid=%b data=%h err=%0d job_ready=%b want 1 0000abcd 2 0",
                         i, res_valid, res_data, res_errors, job_ready);
            end
            if (i == 2) begin
                operation_done = 1'b1; data_out = 32'hFFFF_FFFF; num_of_errors = 2'd3;
            end else begin
                operation_done = 1'b0;
            end
            tick;
        end
        operation_done = 1'b0;
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'h0000_ABCD || res_timeout !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_hold: got valid=%b data=%h to=%b want 1 0000abcd 0",
                     res_valid, res_data, res_timeout);
        end
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || job_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_accept: got valid=%b job_ready=%b want 0 1", res_valid, job_ready);
        end
    endtask

    task automatic test_reset_mid_access;
        job_valid = 1'b1; job_ctrl = 2'd0; job_width = 2'd1; job_data = 32'h77; job_noise = 32'h0;
        tick;
        job_valid = 1'b0;
        tick;
        checks++;
        if ({PSEL, PENABLE} !== 2'b11 || PADDR !== 20'h04) begin
            errors++;
            $display("FAIL mid_access_setup: got sel/en=%b%b addr=%h want 11 00004", PSEL, PENABLE, PADDR);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got sel=%b en=%b res_valid=%b want 0 0 0", PSEL, PENABLE, res_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        tick;
        drive_job(2'd0, 2'd1, 32'h0000_0077, 32'h0,
                  {8'h00, 8'h00, 8'h04, 8'h08}, {32'h0, 32'h0, 32'h77, 32'h1}, 3);
        complete_done(0, 32'h0000_0077, 2'd0);
    endtask

    task automatic test_ctrl3;
        drive_job(2'd3, 2'd1, 32'h0000_0010, 32'h0000_0005,
                  {8'h00, 8'h00, 8'h00, 8'h04}, {32'h0, 32'h0, 32'h3, 32'h10}, 2);
        expect_timeout();
    endtask

    initial begin
        test_reset();
        test_first_job();
        test_repeat_job();
        test_full_channel();
        test_timeout();
        test_backpressure();
        test_reset_mid_access();
        test_ctrl3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
